// File: rtl/hs4_rx_responder_if.sv
// Handshake bundle for hs4_rx_responder: 4-phase req/ack/data from the foreign
// sender plus the local valid/ready drain side.
interface hs4_rx_responder_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          async_req;
  logic [DW-1:0] async_data;
  logic          async_ack;
  logic [DW-1:0] dst_data;
  logic          dst_valid;
  logic          dst_ready;
  logic [CW-1:0] count;
  logic          proto_err;

  modport slave (
    input  async_req, async_data, dst_ready,
    output async_ack, dst_data, dst_valid, count, proto_err
  );

  modport master (
    output async_req, async_data, dst_ready,
    input  async_ack, dst_data, dst_valid, count, proto_err
  );
endinterface

// File: rtl/hs4_rx_responder.sv
// Responder end of a 4-phase req/ack handshake: synchronizes req, captures the held data
// word into a FIFO and drains it on valid/ready. Define HS4_RESP_ERR_EN for the sticky error.
module hs4_rx_responder #(
  parameter int unsigned DW          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEPTH       = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  hs4_rx_responder_if.slave hs_io
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StWaitSpace, StWaitReqLow} state_e;

  state_e                 state_q;
  logic                   ack_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [DW-1:0]          mem_q [DEPTH];
  logic [CW-1:0]          count;
  logic                   req_s, full, empty, push, pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], hs_io.async_req};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // Write decision looks only at this cycle's full flag, so a same-cycle pop never helps.
  assign push  = req_s && !full && ((state_q == StIdle) || (state_q == StWaitSpace));
  assign pop   = !empty && hs_io.dst_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_s) begin
            if (!full) begin
              ack_q   <= 1'b1;
              state_q <= StWaitReqLow;
            end else begin
              state_q <= StWaitSpace;
            end
          end
        end
        StWaitSpace: begin
          if (!req_s) begin
            state_q <= StIdle;
          end else if (!full) begin
            ack_q   <= 1'b1;
            state_q <= StWaitReqLow;
          end
        end
        StWaitReqLow: begin
          if (!req_s) begin
            ack_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef HS4_RESP_ERR_EN
  logic proto_err_q;

  // Sender withdrew req before we could accept it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      proto_err_q <= 1'b0;
    end else if ((state_q == StWaitSpace) && !req_s) begin
      proto_err_q <= 1'b1;
    end
  end

  assign hs_io.proto_err = proto_err_q;
`else
  assign hs_io.proto_err = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= hs_io.async_data;
        wr_ptr_q                <= wr_ptr_q + CW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + CW'(1);
      end
    end
  end

  assign hs_io.async_ack = ack_q;
  assign hs_io.dst_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign hs_io.dst_valid = !empty;
  assign hs_io.count     = count;
endmodule

// File: tb/tb_hs4_rx_responder.sv
// Directed bench for hs4_rx_responder (DW=8, SYNC_STAGES=2, DEPTH=4).
module tb_hs4_rx_responder;
  localparam bit ErrEn =
`ifdef HS4_RESP_ERR_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk, rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  hs4_rx_responder_if #(.DW(8), .DEPTH(4)) hs ();

  hs4_rx_responder #(.DW(8), .SYNC_STAGES(2), .DEPTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hs_io (hs.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic v, input string tag);
    for (int i = 0; i < 30 && hs.async_ack !== v; i++) tick();
    check(tag, 32'(hs.async_ack), 32'(v));
  endtask

  task automatic xfer(input logic [7:0] d);
    hs.async_data = d;
    hs.async_req  = 1'b1;
    wait_ack(1'b1, "xfer_ack_rise");
    hs.async_req  = 1'b0;
    wait_ack(1'b0, "xfer_ack_fall");
  endtask

  initial begin
    rst           = 1'b1;
    hs.async_req  = 1'b0;
    hs.async_data = '0;
    hs.dst_ready  = 1'b0;
    tick();
    tick();
    check("rst_ack", 32'(hs.async_ack), 0);
    check("rst_valid", 32'(hs.dst_valid), 0);
    check("rst_count", 32'(hs.count), 0);
    check("rst_err", 32'(hs.proto_err), 0);
    check("rst_data", 32'(hs.dst_data), 0);
    rst = 1'b0;
    tick();

    // Single word: req sampled at E0, ack/valid after E2, pop at E3.
    hs.dst_ready  = 1'b1;
    hs.async_data = 8'hA5;
    hs.async_req  = 1'b1;
    tick();
    check("e0_ack", 32'(hs.async_ack), 0);
    tick();
    check("e1_ack", 32'(hs.async_ack), 0);
    check("e1_valid", 32'(hs.dst_valid), 0);
    tick();
    check("e2_ack", 32'(hs.async_ack), 1);
    check("e2_valid", 32'(hs.dst_valid), 1);
    check("e2_data", 32'(hs.dst_data), 32'hA5);
    check("e2_count", 32'(hs.count), 1);
    tick();
    check("e3_count", 32'(hs.count), 0);
    check("e3_valid", 32'(hs.dst_valid), 0);
    hs.async_req = 1'b0;
    tick();
    check("rel0_ack", 32'(hs.async_ack), 1);
    tick();
    check("rel1_ack", 32'(hs.async_ack), 1);
    tick();
    check("rel2_ack", 32'(hs.async_ack), 0);

    // Fill to full, fifth request parks, pop-on-full gives 4->3->4.
    hs.dst_ready = 1'b0;
    for (int k = 1; k <= 4; k++) xfer(8'(k));
    check("full_count", 32'(hs.count), 4);
    hs.async_data = 8'h05;
    hs.async_req  = 1'b1;
    repeat (6) tick();
    check("park_ack", 32'(hs.async_ack), 0);
    check("park_count", 32'(hs.count), 4);
    check("park_head", 32'(hs.dst_data), 32'h01);
    hs.dst_ready = 1'b1;
    tick();
    hs.dst_ready = 1'b0;
    check("popfull_count", 32'(hs.count), 3);
    check("popfull_ack", 32'(hs.async_ack), 0);
    check("popfull_head", 32'(hs.dst_data), 32'h02);
    tick();
    check("late_write_count", 32'(hs.count), 4);
    check("late_write_ack", 32'(hs.async_ack), 1);
    hs.async_req = 1'b0;
    wait_ack(1'b0, "park_ack_fall");
    hs.dst_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check("order_valid", 32'(hs.dst_valid), 1);
      check("order_data", 32'(hs.dst_data), 32'(k));
      tick();
    end
    check("drained_count", 32'(hs.count), 0);
    check("drained_valid", 32'(hs.dst_valid), 0);
    hs.dst_ready = 1'b0;

    // Req held high: one write only, ack stays up.
    hs.async_data = 8'h77;
    hs.async_req  = 1'b1;
    wait_ack(1'b1, "hold_ack_rise");
    hs.async_data = 8'h11;
    repeat (20) tick();
    check("hold_ack", 32'(hs.async_ack), 1);
    check("hold_count", 32'(hs.count), 1);
    check("hold_data", 32'(hs.dst_data), 32'h77);
    hs.async_req = 1'b0;
    wait_ack(1'b0, "hold_ack_fall");
    check("hold_count_after", 32'(hs.count), 1);
    hs.dst_ready = 1'b1;
    tick();
    hs.dst_ready = 1'b0;
    check("hold_drained", 32'(hs.count), 0);

    // Protocol error: req withdrawn while parked on a full FIFO.
    for (int k = 0; k < 4; k++) xfer(8'(8'h10 + k));
    hs.async_data = 8'h99;
    hs.async_req  = 1'b1;
    repeat (6) tick();
    check("perr_parked_ack", 32'(hs.async_ack), 0);
    check("perr_before", 32'(hs.proto_err), 0);
    hs.async_req = 1'b0;
    repeat (6) tick();
    check("perr_set", 32'(hs.proto_err), 32'(ErrEn));
    check("perr_count", 32'(hs.count), 4);
    check("perr_ack", 32'(hs.async_ack), 0);
    repeat (10) tick();
    check("perr_sticky", 32'(hs.proto_err), 32'(ErrEn));
    check("perr_no_write", 32'(hs.count), 4);
    hs.dst_ready = 1'b1;
    tick();
    hs.dst_ready = 1'b0;
    xfer(8'h55);
    check("perr_idle_write", 32'(hs.count), 4);
    hs.dst_ready = 1'b1;
    check("perr_d0", 32'(hs.dst_data), 32'h11);
    tick();
    check("perr_d1", 32'(hs.dst_data), 32'h12);
    tick();
    check("perr_d2", 32'(hs.dst_data), 32'h13);
    tick();
    check("perr_d3", 32'(hs.dst_data), 32'h55);
    tick();
    check("perr_empty", 32'(hs.count), 0);
    hs.dst_ready = 1'b0;

    // Async reset mid-transfer with ack=1, count=2.
    xfer(8'hC1);
    hs.async_data = 8'hC2;
    hs.async_req  = 1'b1;
    wait_ack(1'b1, "rstmid_ack_rise");
    check("rstmid_count_pre", 32'(hs.count), 2);
    #2 rst = 1'b1;
    #1;
    check("rstmid_ack", 32'(hs.async_ack), 0);
    check("rstmid_count", 32'(hs.count), 0);
    check("rstmid_valid", 32'(hs.dst_valid), 0);
    check("rstmid_err", 32'(hs.proto_err), 0);
    hs.async_req = 1'b0;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("post_rst_ack", 32'(hs.async_ack), 0);
    check("post_rst_count", 32'(hs.count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hs4_rx_responder.md
# hs4_rx_responder

Single-clock responder end of the 4-phase req/ack handshake. Synchronizes an asynchronous request from a foreign sender, captures the sender's held data word into a local FIFO, and returns ack under full 4-phase rules. Drains the FIFO on a valid/ready interface in its own clock domain. Pairs with any 4-phase initiator that holds data stable while req is high.

## Interface
- `DW`, 8, data word width.
- `SYNC_STAGES`, 2, flops in the req synchronizer; legal range 2–4.
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `clk_i` in 1: only clock. All logic is in this domain.
- `rst_i` in 1: reset. Asynchronous, active-high.
- `async_req_i` in 1: request from the foreign domain; synchronized internally.
- `async_data_i` in DW: data word from the foreign domain. The sender holds it stable from the req rise until the ack rise.
- `async_ack_o` out 1: ack, driven directly from a flop.
- `dst_data_o` out DW: FIFO head word.
- `dst_valid_o` out 1: FIFO is not empty.
- `dst_ready_i` in 1: downstream accept.
- `count_o` out $clog2(DEPTH)+1: FIFO occupancy.
- `proto_err_o` out 1: sticky protocol-error flag.

## Operation
- Synchronizer:
  - `async_req_i` passes through SYNC_STAGES flops.
  - `req_s` is the last stage.
  - No other async input is synchronized.
  - `async_data_i` is sampled only while `req_s`=1 and the FSM is writing.
- FSM states:
  - IDLE
    - `req_s`=1 and FIFO not full: write `async_data_i` to the FIFO, set ack to 1, go to WAIT_REQ_LOW.
    - `req_s`=1 and FIFO full: go to WAIT_SPACE. Ack stays 0.
  - WAIT_SPACE
    - FIFO not full and `req_s`=1: write the word, set ack to 1, go to WAIT_REQ_LOW.
    - `req_s`=0: protocol violation. Set `proto_err_o`, go to IDLE, no write.
  - WAIT_REQ_LOW
    - `req_s`=0: set ack to 0, go to IDLE.
    - A new transfer needs `req_s` to be seen low first. A req that stays high never causes a second write.
- FIFO:
  - Circular buffer with pointers of width log2(DEPTH)+1. The MSB distinguishes full from empty, and pointers wrap naturally.
  - Full = count equals DEPTH. Empty = count equals 0.
  - A pop happens when `dst_valid_o` & `dst_ready_i`.
  - The write decision uses the current-cycle full flag only. A pop in the same cycle does not allow a write into a full FIFO; the write happens on the next cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO: count is unchanged.
- `dst_data_o` comes from the head entry (combinational read). It is stable while `dst_valid_o`=1 and `dst_ready_i`=0.
- `proto_err_o` stays set until reset.

## Timing
- Reset values:
  - `async_ack_o`=0, `dst_valid_o`=0, `count_o`=0, `proto_err_o`=0, `dst_data_o`=0.
  - State is IDLE and the synchronizer flops are cleared.
- Latency:
  - `async_req_i` is sampled high at edge E0.
  - `req_s` is high after edge E(SYNC_STAGES-1).
  - At E(SYNC_STAGES) the FIFO write happens.
  - `async_ack_o` and `dst_valid_o` rise together, just after E(SYNC_STAGES).
- Ack release: `async_ack_o` falls SYNC_STAGES+1 edges after req is sampled low.
- Throughput:
  - One word per full 4-phase cycle.
  - Minimum 2·(SYNC_STAGES+1) cycles of `clk_i` per word, plus sender-side sync delay.
- Reset mid-transfer:
  - Ack drops asynchronously and the FIFO contents are discarded.
  - The sender must also be reset; a req still high after reset is treated as a new transfer.

## Configuration
- `HS4_RESP_ERR_EN` defined:
  - The WAIT_SPACE violation detect is compiled in, and `proto_err_o` behaves as above.
- `HS4_RESP_ERR_EN` not defined:
  - `proto_err_o` is tied to 0 and the sticky flop is removed.
  - WAIT_SPACE with `req_s`=0 still returns silently to IDLE with no write.

## Test plan
- Single word, DW=8, SYNC_STAGES=2:
  - Stimulus: raise req with data 0xA5 at E0, `dst_ready_i`=1.
  - Required: ack and `dst_valid_o` high after E2, `dst_data_o`=0xA5, popped at E3, `count_o` back to 0.
  - Then drop req; ack falls 3 edges after req is sampled low.
- Fill to full, DEPTH=4:
  - Stimulus: `dst_ready_i`=0, five transfers 0x01–0x05.
  - Required: `count_o`=4 after the fourth; fifth request parks in WAIT_SPACE with ack=0.
  - Then assert `dst_ready_i` for one cycle: 0x01 popped, 0x05 written the following cycle, ack rises, order 0x02..0x05 preserved.
- Pop on full in same cycle as a pending request:
  - Stimulus: FIFO full and pending request, with a pop.
  - Required: no write that cycle; write on the next edge; count goes 4→3→4.
- Req held high after ack:
  - Stimulus: keep req high for 20 cycles after ack.
  - Required: exactly one FIFO write, ack stays 1.
- Protocol error (macro on):
  - Stimulus: FIFO full, req rises then falls before space frees.
  - Required: `proto_err_o`=1 and stays 1, no write, state IDLE.
  - With the macro off: `proto_err_o`=0, same behaviour otherwise.
- Async reset mid-transfer:
  - Stimulus: pulse `rst_i` while ack=1 and count=2.
  - Required: ack=0, count=0, valid=0 immediately.
